// File: rtl/dyn_phase_pkg.sv
// Shared constants and types for the dynamic PLL phase-sweep master.
package dyn_phase_pkg;

  localparam int unsigned MinGapDefault  = 16;
  localparam int unsigned TimeoutDefault = 255;

  localparam logic [15:0] RegCntAddr = 16'h0000;
  localparam logic [15:0] RegDirAddr = 16'h0004;

  typedef enum logic [2:0] {
    StIdle,
    StWrCnt,
    StRdCnt,
    StWrDir,
    StGapWait,
    StFinish
  } state_e;

endpackage

// File: rtl/dyn_phase_avm_xfer.sv
// Single Avalon-MM transfer engine: holds the bus until waitrequest drops or the
// timeout expires, and reports completion/timeout in the final bus cycle.
module dyn_phase_avm_xfer
  import dyn_phase_pkg::*;
#(
  parameter int unsigned P_TIMEOUT = TimeoutDefault  // must be >= 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o,
  output logic        avm_cs_o,
  output logic        avm_begintransfer_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [15:0] avm_address_o,
  output logic [31:0] avm_writedata_o,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_waitrequest_i
);

  localparam int unsigned CntW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastWait = CntW'(P_TIMEOUT - 1);

  logic            active_q, active_d;
  logic            begin_q, begin_d;
  logic            wr_q, wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    active_d   = active_q;
    begin_d    = 1'b0;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    done_o     = 1'b0;
    timeout_o  = 1'b0;

    if (active_q) begin
      if (!avm_waitrequest_i) begin
        active_d = 1'b0;
        done_o   = 1'b1;
        if (!wr_q) begin
          rdata_d = avm_readdata_i;
        end
      end else if (wait_cnt_q == LastWait) begin
        active_d  = 1'b0;
        timeout_o = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CntW'(1);
      end
    end else if (req_i) begin
      // Requests are only taken while idle, so a back-to-back request always
      // sees one dead bus cycle after the previous completion.
      active_d   = 1'b1;
      begin_d    = 1'b1;
      wr_d       = we_i;
      addr_d     = addr_i;
      wdata_d    = wdata_i;
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      begin_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      active_q   <= active_d;
      begin_q    <= begin_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Pass the bus value through in the completion cycle so the caller can act on it.
  assign rdata_o             = (done_o && !wr_q) ? avm_readdata_i : rdata_q;
  assign avm_cs_o            = active_q;
  assign avm_begintransfer_o = begin_q;
  assign avm_read_o          = active_q & ~wr_q;
  assign avm_write_o         = active_q & wr_q;
  assign avm_address_o       = addr_q;
  assign avm_writedata_o     = wdata_q;

endmodule

// File: rtl/dyn_phase_sweep_mst.sv
// PLL dynamic phase sweep sequencer: selects a counter, verifies the selection,
// then issues a programmed number of phase-step writes spaced by a gap.
module dyn_phase_sweep_mst
  import dyn_phase_pkg::*;
#(
  parameter int unsigned P_MIN_GAP = MinGapDefault,
  parameter int unsigned P_TIMEOUT = TimeoutDefault
) (
  input  logic        CLK100M,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [3:0]  CNT_SEL,
  input  logic        DIR,
  input  logic [7:0]  STEPS,
  input  logic [15:0] GAP,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  STEP_COUNT,
  output logic        AVM_CS,
  output logic        AVM_BEGINTRANSFER,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [15:0] AVM_ADDRESS,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_WAITREQUEST
);

  localparam logic [15:0] MinGap = 16'(P_MIN_GAP);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  logic        abort_seen_q, abort_seen_d;
  logic        error_q, error_d;
  logic [7:0]  step_q, step_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]  cnt_sel_q, cnt_sel_d;
  logic        dir_q, dir_d;
  logic [7:0]  steps_q, steps_d;
  logic [15:0] gap_q, gap_d;

  logic        xfer_req, xfer_we, xfer_done, xfer_tmo;
  logic [15:0] xfer_addr;
  logic [31:0] xfer_wdata, xfer_rdata;
  logic        in_xfer, abort_now;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^xfer_rdata[31:4];

  assign in_xfer   = (state_q == StWrCnt) || (state_q == StRdCnt) || (state_q == StWrDir);
  assign abort_now = abort_seen_q | ABORT;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    abort_seen_d = abort_seen_q;
    error_d      = error_q;
    step_d       = step_q;
    gap_cnt_d    = gap_cnt_q;
    cnt_sel_d    = cnt_sel_q;
    dir_d        = dir_q;
    steps_d      = steps_q;
    gap_d        = gap_q;
    xfer_req     = 1'b0;
    xfer_we      = 1'b0;
    xfer_addr    = RegCntAddr;
    xfer_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (START && !ABORT) begin
          cnt_sel_d    = CNT_SEL;
          dir_d        = DIR;
          steps_d      = STEPS;
          gap_d        = (GAP > MinGap) ? GAP : MinGap;
          error_d      = 1'b0;
          step_d       = '0;
          pend_d       = 1'b0;
          abort_seen_d = 1'b0;
          state_d      = StWrCnt;
        end
      end
      StWrCnt: begin
        xfer_we    = 1'b1;
        xfer_wdata = {28'd0, cnt_sel_q};
        if (xfer_done) begin
          state_d = abort_now ? StIdle : StRdCnt;
        end
      end
      StRdCnt: begin
        if (xfer_done) begin
          if (abort_now) begin
            state_d = StIdle;
          end else if (xfer_rdata[3:0] != cnt_sel_q) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = (steps_q != 8'd0) ? StWrDir : StFinish;
          end
        end
      end
      StWrDir: begin
        xfer_we    = 1'b1;
        xfer_addr  = RegDirAddr;
        xfer_wdata = {30'd0, dir_q, 1'b1};
        if (xfer_done) begin
          step_d    = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
          gap_cnt_d = '0;
          state_d   = abort_now ? StIdle : StGapWait;
        end
      end
      StGapWait: begin
        if (ABORT) begin
          state_d = StIdle;
        end else if ({1'b0, gap_cnt_q} + 17'd1 >= {1'b0, gap_q}) begin
          state_d = (step_q < steps_q) ? StWrDir : StFinish;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Transfer bookkeeping shared by the three bus states; an abort is only
    // remembered here and honoured when the transfer ends.
    if (in_xfer) begin
      xfer_req = !pend_q;
      pend_d   = !(xfer_done || xfer_tmo);
      if (ABORT) begin
        abort_seen_d = 1'b1;
      end
      if (xfer_done || xfer_tmo) begin
        abort_seen_d = 1'b0;
      end
      if (xfer_tmo) begin
        error_d = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      pend_q       <= 1'b0;
      abort_seen_q <= 1'b0;
      error_q      <= 1'b0;
      step_q       <= '0;
      gap_cnt_q    <= '0;
      cnt_sel_q    <= '0;
      dir_q        <= 1'b0;
      steps_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      abort_seen_q <= abort_seen_d;
      error_q      <= error_d;
      step_q       <= step_d;
      gap_cnt_q    <= gap_cnt_d;
      cnt_sel_q    <= cnt_sel_d;
      dir_q        <= dir_d;
      steps_q      <= steps_d;
      gap_q        <= gap_d;
    end
  end

  assign BUSY       = (state_q != StIdle) && (state_q != StFinish);
  assign DONE       = (state_q == StFinish);
  assign ERROR      = error_q;
  assign STEP_COUNT = step_q;

  dyn_phase_avm_xfer #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_xfer (
    .clk_i               (CLK100M),
    .rst_ni              (RESET_N),
    .req_i               (xfer_req),
    .we_i                (xfer_we),
    .addr_i              (xfer_addr),
    .wdata_i             (xfer_wdata),
    .done_o              (xfer_done),
    .timeout_o           (xfer_tmo),
    .rdata_o             (xfer_rdata),
    .avm_cs_o            (AVM_CS),
    .avm_begintransfer_o (AVM_BEGINTRANSFER),
    .avm_read_o          (AVM_READ),
    .avm_write_o         (AVM_WRITE),
    .avm_address_o       (AVM_ADDRESS),
    .avm_writedata_o     (AVM_WRITEDATA),
    .avm_readdata_i      (AVM_READDATA),
    .avm_waitrequest_i   (AVM_WAITREQUEST)
  );

endmodule

// File: tb/tb_dyn_phase_sweep_mst.sv
// Directed bench for dyn_phase_sweep_mst with a model Avalon slave and bus monitor.
module tb_dyn_phase_sweep_mst;

  logic        CLK100M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [3:0]  CNT_SEL = '0;
  logic        DIR = 1'b0;
  logic [7:0]  STEPS = '0;
  logic [15:0] GAP = '0;
  logic        BUSY, DONE, ERROR;
  logic [7:0]  STEP_COUNT;
  logic        AVM_CS, AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE;
  logic [15:0] AVM_ADDRESS;
  logic [31:0] AVM_WRITEDATA, AVM_READDATA;
  logic        AVM_WAITREQUEST;

  dyn_phase_sweep_mst dut (
    .CLK100M           (CLK100M),
    .RESET_N           (RESET_N),
    .START             (START),
    .ABORT             (ABORT),
    .CNT_SEL           (CNT_SEL),
    .DIR               (DIR),
    .STEPS             (STEPS),
    .GAP               (GAP),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .ERROR             (ERROR),
    .STEP_COUNT        (STEP_COUNT),
    .AVM_CS            (AVM_CS),
    .AVM_BEGINTRANSFER (AVM_BEGINTRANSFER),
    .AVM_READ          (AVM_READ),
    .AVM_WRITE         (AVM_WRITE),
    .AVM_ADDRESS       (AVM_ADDRESS),
    .AVM_WRITEDATA     (AVM_WRITEDATA),
    .AVM_READDATA      (AVM_READDATA),
    .AVM_WAITREQUEST   (AVM_WAITREQUEST)
  );

  always #5 CLK100M = ~CLK100M;

  // Model slave: wait_n waitrequest cycles per transfer, optional stuck or bad readback.
  int unsigned wait_n = 1;
  int unsigned wcnt = 0;
  logic        stuck = 1'b0;
  logic        bad = 1'b0;
  logic [31:0] reg0 = '0;

  assign AVM_WAITREQUEST = AVM_CS && (stuck || (wcnt < wait_n));
  assign AVM_READDATA    = bad ? 32'd5 : reg0;

  always @(posedge CLK100M) begin
    if (AVM_CS && AVM_WAITREQUEST) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (AVM_CS && AVM_WRITE && !AVM_WAITREQUEST && AVM_ADDRESS == 16'h0000)
      reg0 <= AVM_WRITEDATA;
  end

  // Bus monitor, sampled mid-cycle.
  int          cyc = 0;
  logic        mon_clr = 1'b0;
  logic [31:0] exp_wr4 = '0;
  int          n_wr0, n_wr4, n_rd, n_begin, n_done, wr4_bad, proto_err;
  int          min_sp, last_dir, cs_run, cs_max;
  logic        last_dir_v;
  logic [31:0] wr0_data;
  logic        prev_cs = 1'b0, prev_wait = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic        cont;

  assign cont = prev_cs && prev_wait;

  always @(posedge CLK100M) cyc <= cyc + 1;

  always @(negedge CLK100M) begin
    if (mon_clr) begin
      n_wr0 <= 0; n_wr4 <= 0; n_rd <= 0; n_begin <= 0; n_done <= 0;
      wr4_bad <= 0; proto_err <= 0; min_sp <= 32'h7fff_ffff; last_dir <= 0;
      last_dir_v <= 1'b0; cs_run <= 0; cs_max <= 0; wr0_data <= '0;
    end else begin
      if (AVM_CS) begin
        if (AVM_READ == AVM_WRITE) proto_err <= proto_err + 1;
        if (AVM_BEGINTRANSFER == cont) proto_err <= proto_err + 1;
        if (cont && (AVM_ADDRESS != prev_addr || AVM_WRITEDATA != prev_wdata ||
                     AVM_WRITE != prev_we)) proto_err <= proto_err + 1;
        if (prev_cs && !prev_wait) proto_err <= proto_err + 1;
        if (AVM_BEGINTRANSFER) n_begin <= n_begin + 1;
        if (AVM_BEGINTRANSFER && AVM_WRITE && AVM_ADDRESS == 16'h0004) begin
          if (last_dir_v && (cyc - last_dir) < min_sp) min_sp <= cyc - last_dir;
          last_dir   <= cyc;
          last_dir_v <= 1'b1;
        end
        if (!AVM_WAITREQUEST) begin
          if (AVM_READ) n_rd <= n_rd + 1;
          else if (AVM_ADDRESS == 16'h0000) begin
            n_wr0    <= n_wr0 + 1;
            wr0_data <= AVM_WRITEDATA;
          end else if (AVM_ADDRESS == 16'h0004) begin
            n_wr4 <= n_wr4 + 1;
            if (AVM_WRITEDATA != exp_wr4) wr4_bad <= wr4_bad + 1;
          end else proto_err <= proto_err + 1;
        end
        cs_run <= cs_run + 1;
        if (cs_run + 1 > cs_max) cs_max <= cs_run + 1;
      end else begin
        cs_run <= 0;
        if (AVM_READ || AVM_WRITE || AVM_BEGINTRANSFER) proto_err <= proto_err + 1;
      end
      if (DONE) n_done <= n_done + 1;
    end
    prev_cs    <= AVM_CS;
    prev_wait  <= AVM_WAITREQUEST;
    prev_we    <= AVM_WRITE;
    prev_addr  <= AVM_ADDRESS;
    prev_wdata <= AVM_WRITEDATA;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100M);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge CLK100M);
    #1 mon_clr = 1'b0;
  endtask

  task automatic start_sweep(input logic [3:0] cs, input logic d, input logic [7:0] st,
                             input logic [15:0] g);
    CNT_SEL = cs; DIR = d; STEPS = st; GAP = g;
    exp_wr4 = {30'd0, d, 1'b1};
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Runs a sweep to completion; inputs are scrambled and START re-pulsed mid-sweep.
  task automatic run_sweep(input logic [3:0] cs, input logic d, input logic [7:0] st,
                           input logic [15:0] g, output logic to);
    to = 1'b1;
    start_sweep(cs, d, st, g);
    CNT_SEL = ~cs; DIR = ~d; STEPS = st + 8'd7; GAP = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      START = (i == 3) && BUSY;
      tick();
      START = 1'b0;
      if (!BUSY) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) tick();
  endtask

  typedef struct {
    logic [3:0]  cnt_sel;
    logic        dir;
    logic [7:0]  steps;
    logic [15:0] gap;
    logic        bad;
    int unsigned waitn;
    logic        exp_err;
    int          exp_done;
    logic [7:0]  exp_steps;
    int          exp_nwr4;
  } vec_t;

  vec_t vecs[6];
  logic to;
  int   gap_eff;
  int   budget_ok;

  initial begin
    vecs[0] = '{4'd3,  1'b1, 8'd4, 16'd20, 1'b0, 1, 1'b0, 1, 8'd4, 4};
    vecs[1] = '{4'd3,  1'b1, 8'd4, 16'd20, 1'b1, 1, 1'b1, 0, 8'd0, 0};
    vecs[2] = '{4'd9,  1'b0, 8'd0, 16'd2,  1'b0, 1, 1'b0, 1, 8'd0, 0};
    vecs[3] = '{4'd12, 1'b0, 8'd3, 16'd2,  1'b0, 0, 1'b0, 1, 8'd3, 3};
    vecs[4] = '{4'd5,  1'b1, 8'd2, 16'd17, 1'b1, 3, 1'b0, 1, 8'd2, 2};
    vecs[5] = '{4'd15, 1'b1, 8'd1, 16'd0,  1'b0, 2, 1'b0, 1, 8'd1, 1};

    clr_mon();
    repeat (2) tick();
    check("rst_status", {29'd0, BUSY, DONE, ERROR}, 32'd0);
    check("rst_avm_ctl", {28'd0, AVM_CS, AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE}, 32'd0);
    check("rst_addr", {16'd0, AVM_ADDRESS}, 32'd0);
    check("rst_wdata", AVM_WRITEDATA, 32'd0);
    check("rst_step", {24'd0, STEP_COUNT}, 32'd0);
    RESET_N = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 6; v++) begin
      wait_n = vecs[v].waitn;
      bad    = vecs[v].bad;
      clr_mon();
      run_sweep(vecs[v].cnt_sel, vecs[v].dir, vecs[v].steps, vecs[v].gap, to);
      gap_eff = (vecs[v].gap > 16) ? int'(vecs[v].gap) : 16;
      check("v_end", {31'd0, to}, 32'd0);
      check("v_error", {31'd0, ERROR}, {31'd0, vecs[v].exp_err});
      check("v_busy", {31'd0, BUSY}, 32'd0);
      check("v_done", n_done, vecs[v].exp_done);
      check("v_step_count", {24'd0, STEP_COUNT}, {24'd0, vecs[v].exp_steps});
      check("v_n_wr4", n_wr4, vecs[v].exp_nwr4);
      check("v_n_wr0", n_wr0, 1);
      check("v_wr0_data", wr0_data, {28'd0, vecs[v].cnt_sel});
      check("v_n_rd", n_rd, 1);
      check("v_wr4_data", wr4_bad, 0);
      check("v_spacing", {31'd0, min_sp >= gap_eff}, 32'd1);
      check("v_protocol", proto_err, 0);
    end
    bad = 1'b0;

    // Waitrequest stuck high: bus held exactly P_TIMEOUT cycles, then error.
    wait_n = 1;
    stuck = 1'b1;
    clr_mon();
    run_sweep(4'd3, 1'b1, 8'd2, 16'd20, to);
    stuck = 1'b0;
    check("tmo_end", {31'd0, to}, 32'd0);
    check("tmo_error", {31'd0, ERROR}, 32'd1);
    check("tmo_cs_len", cs_max, 255);
    check("tmo_cs_low", {31'd0, AVM_CS}, 32'd0);
    check("tmo_done", n_done, 0);
    check("tmo_n_wr0", n_wr0, 0);

    // Abort in GAP_WAIT after two of five steps.
    clr_mon();
    start_sweep(4'd3, 1'b1, 8'd5, 16'd20);
    budget_ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (n_wr4 == 2) begin
        budget_ok = 1;
        break;
      end
      tick();
    end
    check("abt_reach_step2", budget_ok, 1);
    repeat (3) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abt_busy", {31'd0, BUSY}, 32'd0);
    check("abt_step", {24'd0, STEP_COUNT}, 32'd2);
    repeat (40) tick();
    check("abt_error", {31'd0, ERROR}, 32'd0);
    check("abt_done", n_done, 0);
    check("abt_n_wr4", n_wr4, 2);

    // Abort during the counter write takes effect at its completion.
    wait_n = 3;
    clr_mon();
    start_sweep(4'd7, 1'b0, 8'd2, 16'd16);
    ABORT = 1'b1;
    repeat (2) tick();
    ABORT = 1'b0;
    repeat (20) tick();
    check("abx_n_wr0", n_wr0, 1);
    check("abx_n_rd", n_rd, 0);
    check("abx_busy_err_done", {30'd0, BUSY, ERROR}, 32'd0);
    check("abx_done", n_done, 0);

    // START together with ABORT in IDLE does not start.
    clr_mon();
    CNT_SEL = 4'd2; STEPS = 8'd1; GAP = 16'd16;
    START = 1'b1; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    check("sa_busy", {31'd0, BUSY}, 32'd0);
    repeat (5) tick();
    check("sa_begin", n_begin, 0);

    // Reset in the middle of the second direction write.
    clr_mon();
    start_sweep(4'd6, 1'b1, 8'd3, 16'd20);
    budget_ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (n_wr4 >= 1 && AVM_CS && AVM_ADDRESS == 16'h0004) begin
        budget_ok = 1;
        break;
      end
      tick();
    end
    check("rmid_reach", budget_ok, 1);
    RESET_N = 1'b0;
    #1;
    check("rmid_status", {29'd0, BUSY, DONE, ERROR}, 32'd0);
    check("rmid_avm_ctl", {28'd0, AVM_CS, AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE}, 32'd0);
    check("rmid_addr_data", {16'd0, AVM_ADDRESS} | AVM_WRITEDATA, 32'd0);
    check("rmid_step", {24'd0, STEP_COUNT}, 32'd0);
    repeat (2) tick();
    RESET_N = 1'b1;
    clr_mon();
    repeat (10) tick();
    check("rmid_no_retry", n_begin, 0);
    wait_n = 1;
    clr_mon();
    run_sweep(4'd6, 1'b0, 8'd2, 16'd16, to);
    check("rclean_end", {31'd0, to}, 32'd0);
    check("rclean_done", n_done, 1);
    check("rclean_step", {24'd0, STEP_COUNT}, 32'd2);
    check("rclean_n_wr4", n_wr4, 2);
    check("rclean_err_proto", {31'd0, ERROR} + proto_err, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dyn_phase_sweep_mst.md
DYN_PHASE_SWEEP_MST -- requirements
Module: dyn_phase_sweep_mst

Interface
REQ-001 SHALL have parameter P_MIN_GAP, default 16, minimum idle cycles between direction writes.
REQ-002 SHALL have parameter P_TIMEOUT, default 255, maximum cycles a transfer may stay in waitrequest.
REQ-003 SHALL have port CLK100M  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port RESET_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  in  1  one-cycle sweep request.
REQ-006 SHALL have port ABORT  in  1  level; stop the sweep early.
REQ-007 SHALL have port CNT_SEL  in  4  PLL counter select to program.
REQ-008 SHALL have port DIR  in  1  1=phase up, 0=phase down.
REQ-009 SHALL have port STEPS  in  8  number of phase steps.
REQ-010 SHALL have port GAP  in  16  cycles between steps.
REQ-011 SHALL have port BUSY  out  1  sweep in progress.
REQ-012 SHALL have port DONE  out  1  one-cycle pulse on successful completion.
REQ-013 SHALL have port ERROR  out  1  sticky; readback mismatch or timeout.
REQ-014 SHALL have port STEP_COUNT  out  8  steps issued in the current or last sweep.
REQ-015 SHALL have Avalon-MM master ports AVM_CS, AVM_BEGINTRANSFER, AVM_READ, AVM_WRITE (out 1), AVM_ADDRESS (out 16), AVM_WRITEDATA (out 32), AVM_READDATA (in 32), AVM_WAITREQUEST (in 1).

Function
REQ-016 SHALL assert AVM_CS and either AVM_READ or AVM_WRITE, with stable address and data, for every cycle of a transfer.
REQ-017 SHALL assert AVM_BEGINTRANSFER in the first cycle of each transfer only.
REQ-018 SHALL complete a transfer in the first cycle where AVM_WAITREQUEST=0 and sample AVM_READDATA in that cycle.
REQ-019 SHALL leave one idle cycle, with CS/READ/WRITE low, between consecutive transfers.
REQ-020 SHALL use states IDLE, WR_CNT, RD_CNT, WR_DIR, GAP_WAIT, and FINISH.
REQ-021 In IDLE, START=1 SHALL latch CNT_SEL, DIR, STEPS, and max(GAP,P_MIN_GAP), clear ERROR and STEP_COUNT, set BUSY, and go to WR_CNT.
REQ-022 WR_CNT SHALL write {28'd0,CNT_SEL} to 0x0000 and then go to RD_CNT.
REQ-023 RD_CNT SHALL read 0x0000.
REQ-024 On a RD_CNT readback[3:0] mismatch, the block SHALL set ERROR and go to IDLE.
REQ-025 On a RD_CNT readback match, the block SHALL go to WR_DIR if STEPS>0, else to FINISH.
REQ-026 WR_DIR SHALL write {30'd0,DIR,1'b1} to 0x0004, increment STEP_COUNT on completion, and go to GAP_WAIT.
REQ-027 GAP_WAIT SHALL count the latched gap, then go to WR_DIR if STEP_COUNT<STEPS, else to FINISH.
REQ-028 FINISH SHALL pulse DONE for one cycle, clear BUSY, and return to IDLE.
REQ-029 START while BUSY=1 SHALL be ignored.
REQ-030 A change on CNT_SEL, DIR, STEPS, or GAP during a sweep SHALL have no effect on that sweep.
REQ-031 An ABORT seen in GAP_WAIT SHALL cause an immediate return to IDLE.
REQ-032 An ABORT seen during a transfer SHALL take effect at transfer completion.
REQ-033 An aborted sweep SHALL not pulse DONE and SHALL not set ERROR.
REQ-034 A transfer exceeding P_TIMEOUT waitrequest cycles SHALL drop CS/READ/WRITE, set ERROR, and go to IDLE.
REQ-035 STEP_COUNT SHALL saturate at 255.
REQ-036 STEP_COUNT SHALL hold its value after the sweep ends.
REQ-037 START and ABORT in the same IDLE cycle SHALL not start a sweep.

Reset
REQ-038 RESET_N low SHALL force IDLE.
REQ-039 RESET_N low SHALL force BUSY, DONE, ERROR, AVM_CS, AVM_BEGINTRANSFER, AVM_READ, and AVM_WRITE to 0.
REQ-040 RESET_N low SHALL force STEP_COUNT=0, AVM_ADDRESS=16'h0000, and AVM_WRITEDATA=32'h0.
REQ-041 Reset mid-transfer SHALL abandon the transfer immediately with no retry after release.

Structure
REQ-042 Package dyn_phase_pkg SHALL hold the register addresses 0x0000 and 0x0004, the state enum, and the P_MIN_GAP and P_TIMEOUT defaults.
REQ-043 Sub-module dyn_phase_avm_xfer SHALL own a single transfer: begintransfer generation, waitrequest hold, timeout, readdata capture, and done/timeout strobes.
REQ-044 The top-level SHALL contain only the sequencer, the counters, and the status outputs.

Verification
REQ-045 Nominal sweep: CNT_SEL=3, DIR=1, STEPS=4, GAP=20, against a model slave with 1-cycle waitrequest -> write 0x0000=3, readback 3, four writes 0x0004=3 at least 20 cycles apart, DONE once, STEP_COUNT=4.
REQ-046 Readback mismatch: the slave returns 5 for 0x0000 -> ERROR=1, no 0x0004 write, BUSY=0.
REQ-047 Waitrequest stuck high -> ERROR after 255 cycles, CS low the next cycle.
REQ-048 STEPS=0 and GAP=2: STEPS=0 -> write and read only, then DONE; in any sweep with GAP=2, the direction-write spacing is at least 16 cycles.
REQ-049 ABORT raised in GAP_WAIT after step 2 of 5 -> IDLE next cycle, STEP_COUNT=2, no DONE, ERROR=0.
REQ-050 RESET_N pulsed mid-WR_DIR -> all outputs at reset values, and a subsequent START runs a clean sweep.
